// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions (RX and TX).
//   UART_DATA_W     - data bits per frame
//   uart_rx_state_t - receiver FSM state encoding
//   uart_div()      - rounded clock divider for a given baud and oversample ratio
// Optional feature macro: UART_RX_PARITY_EN (adds the RX_PARITY state).
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_RX_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_BREAK
  } uart_rx_state_t;

  // round(freq / (baud * os))
  function automatic int unsigned uart_div(input int unsigned freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned per_tick;
    per_tick = baud * os;
    return (freq + per_tick / 2) / per_tick;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-clock tick every DIV clocks.
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-high reset
//   restart - synchronous restart; the next tick comes DIV clocks later
//   tick    - registered one-clock pulse
module uart_baud_tick #(
  parameter int unsigned DIV = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Divider counter with phase restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver, 8 data bits LSB first, 1 stop bit.
// Ports:
//   clk         - system clock
//   reset       - asynchronous active-high reset
//   rxd         - asynchronous serial input, idles high
//   rx_data     - received byte, stable while rx_valid=1
//   rx_valid    - byte available, held until rx_valid & rx_ready
//   rx_ready    - consumer accept
//   framing_err - one-clock pulse: stop bit sampled low
//   overrun     - one-clock pulse: new byte dropped, holding register full
//   parity_err  - one-clock pulse with the delivery (UART_RX_PARITY_EN only)
// Optional feature macro: UART_RX_PARITY_EN adds the parity bit, the
// parity_err port and parameter PARITY_ODD (0 = even parity).
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned UART_CLK_FREQ = 24_000_000,
  parameter int unsigned UART_BAUD     = 115_200,
  parameter int unsigned OVERSAMPLE    = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit          PARITY_ODD    = 1'b0
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rxd,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   framing_err,
  output logic                   overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                   parity_err
`endif
);

  localparam int unsigned DIV   = uart_div(UART_CLK_FREQ, UART_BAUD, OVERSAMPLE);
  localparam int unsigned H     = OVERSAMPLE / 2;
  localparam int unsigned S_W   = $clog2(OVERSAMPLE);
  localparam int unsigned BI_W  = $clog2(UART_DATA_W);
  localparam logic [S_W-1:0]  S_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0]  S_A     = S_W'(H - 1);
  localparam logic [S_W-1:0]  S_B     = S_W'(H);
  localparam logic [S_W-1:0]  S_C     = S_W'(H + 1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(UART_DATA_W - 1);

  uart_rx_state_t         state;
  logic                   sync1;
  logic                   rxs;
  logic                   rxs_d;
  logic [S_W-1:0]         s;
  logic [BI_W-1:0]        bit_idx;
  logic [UART_DATA_W-1:0] shreg;
  logic [1:0]             samp;
  logic                   tick;
  logic                   restart_c;
  logic                   decide_c;
  logic                   bit_c;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad;
`endif

  // 2-FF synchroniser plus a delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  // Start edge, decision strobe and 2-of-3 majority vote
  always_comb begin
    restart_c = (state == RX_IDLE) && rxs_d && !rxs;
    decide_c  = tick && (s == S_C);
    bit_c     = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
  end

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_c),
    .tick    (tick)
  );

  // Frame FSM, sample counter, shift register and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RX_IDLE;
      s           <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      samp        <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (tick) begin
        s <= (s == S_LAST) ? '0 : s + S_W'(1);
        if (s == S_A) samp[0] <= rxs;
        if (s == S_B) samp[1] <= rxs;
      end

      case (state)
        RX_IDLE: begin
          // overrides the tick increment above so s starts at 0
          s       <= '0;
          bit_idx <= '0;
          if (restart_c) state <= RX_START;
        end
        RX_START: begin
          if (decide_c) begin
            bit_idx <= '0;
            state   <= bit_c ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (decide_c) begin
            shreg <= {bit_c, shreg[UART_DATA_W-1:1]};
            if (bit_idx == BI_LAST) begin
              bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= RX_PARITY;
`else
              state   <= RX_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + BI_W'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        RX_PARITY: begin
          if (decide_c) begin
            par_bad <= ((^shreg) ^ bit_c) != PARITY_ODD;
            state   <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (decide_c) begin
            if (bit_c) begin
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun  <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              parity_err <= par_bad;
`endif
              state <= RX_IDLE;
            end else begin
              framing_err <= 1'b1;
              state       <= RX_BREAK;
            end
          end
        end
        RX_BREAK: begin
          // hold off until the line returns high so a stuck-low line cannot retrigger
          if (rxs) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: self-checking bench for uart_rx_os at default parameters.
// Expected bytes are queued as frames are sent and compared at each handshake.
// Build with UART_RX_PARITY_EN defined to include the parity scenario.
module tb_uart_rx_os;

  localparam int unsigned BIT_CLK = 208;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip;
  int         pe_cnt   = 0;
  int         pe_coinc = 0;
`endif

  int         checks  = 0;
  int         errors  = 0;
  int         cyc     = 0;
  int         rises   = 0;
  int         fe_cnt  = 0;
  int         ov_cnt  = 0;
  int         t_start = 0;
  int         t_valid = 0;
  logic       valid_q = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx_os dut (
    .clk         (clk),
    .reset       (reset),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
    .overrun     (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * BIT_CLK) @(negedge clk);
  endtask

  // One frame: start, 8 data bits LSB first, [parity], stop level as given
  task automatic send(input logic [7:0] d, input logic stop);
    rxd     = 1'b0;
    t_start = cyc;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_bits(1);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ par_flip;
    wait_bits(1);
`endif
    rxd = stop;
    wait_bits(1);
  endtask

  // Monitor: event counters and scoreboard compare at each handshake
  always @(negedge clk) begin
    if (reset) begin
      valid_q = 1'b0;
    end else begin
      if (rx_valid && !valid_q) begin
        rises++;
        t_valid = cyc;
      end
      if (framing_err) fe_cnt++;
      if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) begin
        pe_cnt++;
        if (rx_valid && !valid_q) pe_coinc++;
      end
`endif
      if (rx_valid && rx_ready) begin
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      valid_q = rx_valid;
    end
  end

  initial begin
    int r0, f0, o0, lat;
`ifdef UART_RX_PARITY_EN
    int p0, c0;
    par_flip = 1'b0;
`endif
    reset    = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_framing_err", 32'(framing_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    wait_bits(2);

    // 1: plain 0x55 with consumer ready
    r0 = rises; f0 = fe_cnt; o0 = ov_cnt;
    exp_q.push_back(8'h55);
    send(8'h55, 1'b1);
    wait_bits(1);
    lat = t_valid - t_start;
    check("t1_valid_once", 32'(rises - r0), 32'd1);
    check("t1_latency_window", 32'(lat >= 9 * BIT_CLK && lat <= 10 * BIT_CLK), 32'd1);
    check("t1_no_framing", 32'(fe_cnt - f0), 32'd0);
    check("t1_no_overrun", 32'(ov_cnt - o0), 32'd0);

    // 2: 40-clock glitch is a false start
    r0 = rises; f0 = fe_cnt; o0 = ov_cnt;
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    rxd = 1'b1;
    wait_bits(3);
    check("t2_no_valid", 32'(rises - r0), 32'd0);
    check("t2_no_framing", 32'(fe_cnt - f0), 32'd0);
    check("t2_no_overrun", 32'(ov_cnt - o0), 32'd0);

    // 3: bad stop, line held low, then a good byte
    r0 = rises; f0 = fe_cnt; o0 = ov_cnt;
    send(8'hA5, 1'b0);
    wait_bits(20);
    rxd = 1'b1;
    wait_bits(2);
    exp_q.push_back(8'h3C);
    send(8'h3C, 1'b1);
    wait_bits(1);
    check("t3_one_framing", 32'(fe_cnt - f0), 32'd1);
    check("t3_one_valid", 32'(rises - r0), 32'd1);
    check("t3_no_overrun", 32'(ov_cnt - o0), 32'd0);

    // 4: consumer stalled, second byte overruns
    r0 = rises; o0 = ov_cnt;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    wait_bits(1);
    check("t4_one_overrun", 32'(ov_cnt - o0), 32'd1);
    check("t4_valid_held", 32'(rx_valid), 32'd1);
    check("t4_data_kept", 32'(rx_data), 32'h11);
    check("t4_one_rise", 32'(rises - r0), 32'd1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 check("t4_valid_cleared", 32'(rx_valid), 32'd0);
    check("t4_sb_drained", 32'(exp_q.size()), 32'd0);

    // 5: reset during data bit 4 of 0x7E
    @(negedge clk);
    rxd = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 4; i++) begin
      rxd = (i == 0) ? 1'b0 : 1'b1;
      wait_bits(1);
    end
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_rst_rx_data", 32'(rx_data), 32'd0);
    check("t5_rst_rx_valid", 32'(rx_valid), 32'd0);
    check("t5_rst_framing_err", 32'(framing_err), 32'd0);
    check("t5_rst_overrun", 32'(overrun), 32'd0);
`ifdef UART_RX_PARITY_EN
    check("t5_rst_parity_err", 32'(parity_err), 32'd0);
`endif
    reset = 1'b0;
    wait_bits(2);
    r0 = rises; f0 = fe_cnt;
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1);
    wait_bits(1);
    check("t5_one_valid", 32'(rises - r0), 32'd1);
    check("t5_no_framing", 32'(fe_cnt - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 6: even parity, wrong then correct parity bit on 0x07
    p0 = pe_cnt; c0 = pe_coinc;
    par_flip = 1'b1;
    exp_q.push_back(8'h07);
    send(8'h07, 1'b1);
    wait_bits(1);
    check("t6_parity_err", 32'(pe_cnt - p0), 32'd1);
    check("t6_parity_with_valid", 32'(pe_coinc - c0), 32'd1);
    p0 = pe_cnt;
    par_flip = 1'b0;
    exp_q.push_back(8'h07);
    send(8'h07, 1'b1);
    wait_bits(1);
    check("t6_parity_ok", 32'(pe_cnt - p0), 32'd0);
`endif

    check("sb_final_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
